branch_predictor: RTL and testbench

- Decode/Execute-side counterpart of the fetch redirect interface.
- In Decode, it recognises B-type branches in InstrD, computes the branch target and predicts taken/not-taken from a table of 2-bit saturating counters. The prediction drives PCSrcD/PCBranchD back to Fetch.
- It carries each prediction into Execute and compares it against the ALU outcome. On a mismatch it raises MissPredictionE/BranchReturnE, which Fetch uses to redirect the PC and flush its pipeline register.
- It trains the counter table on every resolved branch.

---
 rtl/branch_predictor_if.sv | 29 ++
 rtl/branch_predictor.sv | 109 ++++++++++
 tb/tb_branch_predictor.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Decode/Execute branch-prediction bus between Fetch/pipeline control and the predictor.
// Latency: carries no state; it only groups the pipeline-facing signals.
// Backpressure: StallD/FlushE arrive from pipeline control, redirects go back to Fetch.
interface branch_predictor_if;
    // Decode-side inputs
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        StallD;
    // Execute-side inputs
    logic        FlushE;
    logic        BranchTakenE;
    // Redirects back to Fetch
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        MissPredictionE;
    logic [31:0] BranchReturnE;

    // Pipeline/Fetch side: supplies instructions and outcomes, consumes redirects
    modport master (
        output InstrD, PCPlus4D, StallD, FlushE, BranchTakenE,
        input  PCSrcD, PCBranchD, MissPredictionE, BranchReturnE
    );

    // Predictor side
    modport slave (
        input  InstrD, PCPlus4D, StallD, FlushE, BranchTakenE,
        output PCSrcD, PCBranchD, MissPredictionE, BranchReturnE
    );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter branch predictor: predicts in Decode, resolves and trains in Execute.
// Latency: prediction and target are combinational in D; resolution is combinational in E, one cycle later.
// Backpressure: StallD, FlushE or a misprediction load a bubble into E; an E redirect masks the D prediction.
module branch_predictor #(
    parameter int          BHT_BITS = 6,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input logic          clk,
    input logic          reset,
    branch_predictor_if.slave bp
);

    localparam int BHT_SIZE = 1 << BHT_BITS;

    // Counter table
    logic [1:0]          r_ctr [BHT_SIZE];

    // Decode -> Execute entry
    logic                r_valid_e;
    logic                r_branch_e;
    logic                r_pred_e;
    logic [31:0]         r_target_e;
    logic [31:0]         r_pc4_e;
    logic [BHT_BITS-1:0] r_idx_e;

    // Decode-stage wires
    logic                w_is_branch_d;
    logic [31:0]         w_pc_d;
    logic [31:0]         w_imm_d;
    logic [31:0]         w_target_d;
    logic [BHT_BITS-1:0] w_idx_d;
    logic                w_pred_d;

    // Execute-stage wires
    logic                w_resolve_e;
    logic                w_miss_e;
    logic [1:0]          w_ctr_e;
    logic [1:0]          w_ctr_next_e;
    logic                w_bubble_e;

    // rs1/rs2/funct3 fields play no part in prediction
    logic                w_unused_instr;
    assign w_unused_instr = ^bp.InstrD[24:12];

    // Decode: recognise B-type, form target and look up the counter (no bypass from the E update)
    always_comb begin
        w_is_branch_d = (bp.InstrD[6:0] == 7'b1100011);
        w_pc_d        = bp.PCPlus4D - 32'd4;
        w_imm_d       = {{20{bp.InstrD[31]}}, bp.InstrD[7], bp.InstrD[30:25],
                         bp.InstrD[11:8], 1'b0};
        w_target_d    = w_pc_d + w_imm_d;
        w_idx_d       = w_pc_d[BHT_BITS+1:2];
        w_pred_d      = w_is_branch_d & r_ctr[w_idx_d][1];
    end

    // Execute: compare the carried prediction with the ALU outcome
    always_comb begin
        w_resolve_e = r_valid_e & r_branch_e & ~reset;
        w_miss_e    = w_resolve_e & (bp.BranchTakenE != r_pred_e);
        w_ctr_e     = r_ctr[r_idx_e];
        w_ctr_next_e = w_ctr_e;
        if (bp.BranchTakenE) begin
            if (w_ctr_e != 2'b11) w_ctr_next_e = w_ctr_e + 2'b01;
        end else begin
            if (w_ctr_e != 2'b00) w_ctr_next_e = w_ctr_e - 2'b01;
        end
        w_bubble_e  = bp.FlushE | w_miss_e | bp.StallD;
    end

    // Outputs: an E-stage redirect always overrides a D-stage prediction
    assign bp.PCSrcD          = w_pred_d & ~w_miss_e & ~reset;
    assign bp.PCBranchD       = w_target_d;
    assign bp.MissPredictionE = w_miss_e;
    assign bp.BranchReturnE   = bp.BranchTakenE ? r_target_e : r_pc4_e;

    // Decode -> Execute register: reset, then bubble, then load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_e  <= 1'b0;
            r_branch_e <= 1'b0;
            r_pred_e   <= 1'b0;
            r_target_e <= 32'd0;
            r_pc4_e    <= 32'd0;
            r_idx_e    <= '0;
        end else if (w_bubble_e) begin
            r_valid_e  <= 1'b0;
            r_branch_e <= 1'b0;
        end else begin
            r_valid_e  <= 1'b1;
            r_branch_e <= w_is_branch_d;
            r_pred_e   <= w_pred_d;
            r_target_e <= w_target_d;
            r_pc4_e    <= bp.PCPlus4D;
            r_idx_e    <= w_idx_d;
        end
    end

    // Counter table: initialise on reset, train only on resolved branches
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_SIZE; i++) begin
                r_ctr[i] <= CTR_INIT;
            end
        end else if (w_resolve_e) begin
            r_ctr[r_idx_e] <= w_ctr_next_e;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed expectations checked with immediate assertions.
// Latency: D outputs checked 1 ns after input change; E outputs checked 1 ns after the loading edge.
// Backpressure: StallD/FlushE/misprediction bubbles exercised by directed steps.
module tb_branch_predictor;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    branch_predictor_if bp_if ();

    branch_predictor #(.BHT_BITS(6), .CTR_INIT(2'b01)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp_if.slave)
    );

    localparam logic [31:0] BEQ  = 32'h00000463;
    localparam logic [31:0] BNE  = 32'hFE001EE3;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] PC4A = 32'hBFC00014;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one clock and land 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc4,
                         input logic taken, input logic stall, input logic flush);
        bp_if.InstrD       = instr;
        bp_if.PCPlus4D     = pc4;
        bp_if.BranchTakenE = taken;
        bp_if.StallD       = stall;
        bp_if.FlushE       = flush;
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        drive(BEQ, PC4A, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        // reset: outputs held low even with a branch in D
        check("rst_pcsrc", {31'd0, bp_if.PCSrcD}, 32'd0);
        check("rst_miss",  {31'd0, bp_if.MissPredictionE}, 32'd0);

        // beq +8, ctr[4]=01 -> not predicted
        #2 reset = 1'b0;
        drive(BEQ, PC4A, 1'b0, 1'b0, 1'b0);
        check("t1_target", bp_if.PCBranchD, 32'hBFC00018);
        check("t1_pcsrc",  {31'd0, bp_if.PCSrcD}, 32'd0);
        check("t1_miss0",  {31'd0, bp_if.MissPredictionE}, 32'd0);
        tick();
        drive(NOP, 32'h0, 1'b1, 1'b0, 1'b0);
        check("t1_miss",   {31'd0, bp_if.MissPredictionE}, 32'd1);
        check("t1_ret",    bp_if.BranchReturnE, 32'hBFC00018);
        tick();
        // ctr[4]=10, E is bubble
        drive(BEQ, PC4A, 1'b0, 1'b0, 1'b0);
        check("t2_bubble", {31'd0, bp_if.MissPredictionE}, 32'd0);
        check("t2_pcsrc",  {31'd0, bp_if.PCSrcD}, 32'd1);
        check("t2_target", bp_if.PCBranchD, 32'hBFC00018);
        tick();
        drive(NOP, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t2_miss",   {31'd0, bp_if.MissPredictionE}, 32'd1);
        check("t2_ret",    bp_if.BranchReturnE, 32'hBFC00014);
        tick();

        // bne -4 target arithmetic, including wrap below zero
        drive(BNE, 32'h00000008, 1'b0, 1'b0, 1'b1);
        check("t3_target0", bp_if.PCBranchD, 32'h00000000);
        check("t3_pcsrc",   {31'd0, bp_if.PCSrcD}, 32'd0);
        drive(BNE, 32'h00000004, 1'b0, 1'b0, 1'b1);
        check("t3_wrap",    bp_if.PCBranchD, 32'hFFFFFFFC);
        tick();

        // 5 taken on ctr[4] starting at 01: 01,10,11,11,11
        begin
            logic [4:0] exp_pred;
            logic [4:0] exp_miss;
            exp_pred = 5'b11110;
            exp_miss = 5'b00001;
            for (int i = 0; i < 5; i++) begin
                drive(BEQ, PC4A, 1'b0, 1'b0, 1'b0);
                check($sformatf("sat_pcsrc%0d", i), {31'd0, bp_if.PCSrcD}, {31'd0, exp_pred[i]});
                tick();
                drive(NOP, 32'h0, 1'b1, 1'b0, 1'b0);
                check($sformatf("sat_miss%0d", i), {31'd0, bp_if.MissPredictionE}, {31'd0, exp_miss[i]});
                tick();
            end
        end
        // one not-taken: 11 -> 10, still predicted taken
        drive(BEQ, PC4A, 1'b0, 1'b0, 1'b0);
        check("nt_pcsrc",  {31'd0, bp_if.PCSrcD}, 32'd1);
        tick();
        drive(NOP, 32'h0, 1'b0, 1'b0, 1'b0);
        check("nt_miss",   {31'd0, bp_if.MissPredictionE}, 32'd1);
        tick();
        drive(BEQ, PC4A, 1'b0, 1'b0, 1'b0);
        check("nt_after",  {31'd0, bp_if.PCSrcD}, 32'd1);
        tick();
        // resolve taken: 10 -> 11, correct prediction
        drive(NOP, 32'h0, 1'b1, 1'b0, 1'b0);
        check("tk_nomiss", {31'd0, bp_if.MissPredictionE}, 32'd0);
        tick();

        // squash: E branch mispredicts while D holds a predicted-taken branch on the same index
        drive(BEQ, PC4A, 1'b0, 1'b0, 1'b0);
        check("sq_pcsrcA", {31'd0, bp_if.PCSrcD}, 32'd1);
        tick();
        drive(BEQ, PC4A, 1'b0, 1'b0, 1'b0);
        check("sq_miss",   {31'd0, bp_if.MissPredictionE}, 32'd1);
        check("sq_pcsrc",  {31'd0, bp_if.PCSrcD}, 32'd0);
        check("sq_ret",    bp_if.BranchReturnE, 32'hBFC00014);
        tick();
        // ctr[4]=10; squashed branch must not be in E
        drive(NOP, 32'h0, 1'b0, 1'b0, 1'b0);
        check("sq_bubble", {31'd0, bp_if.MissPredictionE}, 32'd0);
        tick();
        drive(BEQ, PC4A, 1'b0, 1'b0, 1'b1);
        check("sq_noupd",  {31'd0, bp_if.PCSrcD}, 32'd1);
        tick();

        // nop in D: no prediction, no resolution in E
        drive(NOP, 32'h0, 1'b1, 1'b0, 1'b0);
        check("nop_pcsrc", {31'd0, bp_if.PCSrcD}, 32'd0);
        tick();
        drive(BEQ, PC4A, 1'b1, 1'b1, 1'b0);
        check("nop_miss",  {31'd0, bp_if.MissPredictionE}, 32'd0);
        // stalled branch: prediction held each cycle, nothing enters E
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(BEQ, PC4A, 1'b0, 1'b1, 1'b0);
            check($sformatf("stall_pcsrc%0d", i), {31'd0, bp_if.PCSrcD}, 32'd1);
            check($sformatf("stall_miss%0d", i),  {31'd0, bp_if.MissPredictionE}, 32'd0);
        end
        // ctr[4] is still 10: leave D now, then reset mid-flight
        drive(BEQ, PC4A, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        drive(NOP, 32'h0, 1'b0, 1'b0, 1'b0);
        check("rmid_miss", {31'd0, bp_if.MissPredictionE}, 32'd0);
        tick();
        reset = 1'b0;
        drive(BEQ, PC4A, 1'b0, 1'b0, 1'b0);
        check("rmid_ctr",  {31'd0, bp_if.PCSrcD}, 32'd0);
        check("rmid_e",    {31'd0, bp_if.MissPredictionE}, 32'd0);
        tick();

        // FlushE with a resolving branch: resolution and update still happen
        drive(NOP, 32'h0, 1'b1, 1'b0, 1'b1);
        check("fl_miss",   {31'd0, bp_if.MissPredictionE}, 32'd1);
        check("fl_ret",    bp_if.BranchReturnE, 32'hBFC00018);
        tick();
        drive(BEQ, PC4A, 1'b1, 1'b0, 1'b0);
        check("fl_bubble", {31'd0, bp_if.MissPredictionE}, 32'd0);
        check("fl_upd",    {31'd0, bp_if.PCSrcD}, 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
